// File: rtl/wb_queued_master_if.sv
// rtl/wb_queued_master_if.sv - Wishbone bus, command and response signals of the queued master
interface wb_queued_master_if #(
    parameter int DATA_WL   = 16,
    parameter int ADR_WL    = 16,
    parameter int CMD_DEPTH = 4
);
    localparam int SEL_WL = DATA_WL / 8;
    localparam int LVL_WL = $clog2(CMD_DEPTH) + 1;

    logic                wb_ack_i;
    logic                wb_err_i;
    logic [DATA_WL-1:0]  wb_dat_i;
    logic                wb_cyc_o;
    logic                wb_stb_o;
    logic                wb_we_o;
    logic [SEL_WL-1:0]   wb_sel_o;
    logic [ADR_WL-1:0]   wb_adr_o;
    logic [DATA_WL-1:0]  wb_dat_o;

    logic                cmd_valid_i;
    logic                cmd_ready_o;
    logic                cmd_we_i;
    logic [SEL_WL-1:0]   cmd_sel_i;
    logic [ADR_WL-1:0]   cmd_addr_i;
    logic [DATA_WL-1:0]  cmd_data_i;

    logic                rsp_valid_o;
    logic [DATA_WL-1:0]  rsp_data_o;
    logic                rsp_err_o;
    logic                rsp_timeout_o;
    logic                busy_o;
    logic [LVL_WL-1:0]   level_o;

    modport master (
        input  wb_ack_i, wb_err_i, wb_dat_i,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        input  cmd_valid_i, cmd_we_i, cmd_sel_i, cmd_addr_i, cmd_data_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_data_o, rsp_err_o, rsp_timeout_o, busy_o, level_o
    );

    modport slave (
        output wb_ack_i, wb_err_i, wb_dat_i,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        output cmd_valid_i, cmd_we_i, cmd_sel_i, cmd_addr_i, cmd_data_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_data_o, rsp_err_o, rsp_timeout_o, busy_o, level_o
    );
endinterface

// File: rtl/wb_queued_master.sv
// rtl/wb_queued_master.sv - Wishbone classic master executing queued commands back-to-back
module wb_queued_master #(
    parameter int DATA_WL   = 16,
    parameter int ADR_WL    = 16,
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic               clk,
    input  logic               a_reset_l,
    wb_queued_master_if.master bus
);
    localparam int SEL_WL    = DATA_WL / 8;
    localparam int PTR_WL    = $clog2(CMD_DEPTH);
    localparam int LVL_WL    = PTR_WL + 1;
    localparam int ENT_WL    = 1 + SEL_WL + ADR_WL + DATA_WL;
    localparam int CNT_WL    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_WL-1:0] TO_LAST = CNT_WL'(TO_LAST_I);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t              r_state, w_state_nxt;
    logic [ENT_WL-1:0]   r_mem [CMD_DEPTH];
    logic [PTR_WL-1:0]   r_wr_ptr, r_rd_ptr;
    logic [LVL_WL-1:0]   r_level;

    logic                r_cyc, r_stb, r_we;
    logic [SEL_WL-1:0]   r_sel;
    logic [ADR_WL-1:0]   r_adr;
    logic [DATA_WL-1:0]  r_dat;
    logic [CNT_WL-1:0]   r_cnt;
    logic                r_rsp_valid, r_rsp_err, r_rsp_timeout;
    logic [DATA_WL-1:0]  r_rsp_data;

    logic                w_cyc_nxt, w_stb_nxt, w_we_nxt;
    logic [SEL_WL-1:0]   w_sel_nxt;
    logic [ADR_WL-1:0]   w_adr_nxt;
    logic [DATA_WL-1:0]  w_dat_nxt;
    logic [CNT_WL-1:0]   w_cnt_nxt;
    logic                w_rsp_valid_nxt, w_rsp_err_nxt, w_rsp_timeout_nxt;
    logic [DATA_WL-1:0]  w_rsp_data_nxt;

    logic                w_empty, w_full, w_push, w_pop, w_to_hit, w_to_term;
    logic [ENT_WL-1:0]   w_head;

    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == LVL_WL'(CMD_DEPTH));
    assign w_push   = bus.cmd_valid_i && !w_full;
    assign w_head   = r_mem[r_rd_ptr];
    assign w_to_hit = (TIMEOUT != 0) && (r_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {bus.cmd_we_i, bus.cmd_sel_i, bus.cmd_addr_i, bus.cmd_data_i};
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cyc_nxt         = r_cyc;
        w_stb_nxt         = r_stb;
        w_we_nxt          = r_we;
        w_sel_nxt         = r_sel;
        w_adr_nxt         = r_adr;
        w_dat_nxt         = r_dat;
        w_cnt_nxt         = r_cnt;
        w_rsp_valid_nxt   = 1'b0;
        w_rsp_err_nxt     = r_rsp_err;
        w_rsp_timeout_nxt = r_rsp_timeout;
        w_rsp_data_nxt    = r_rsp_data;
        w_pop             = 1'b0;
        w_to_term         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cyc_nxt = 1'b0;
                w_stb_nxt = 1'b0;
                w_we_nxt  = 1'b0;
                if (!w_empty)
                    w_pop = 1'b1;
            end
            S_ACTIVE: begin
                w_to_term = !bus.wb_err_i && !bus.wb_ack_i && w_to_hit;
                if (bus.wb_err_i || bus.wb_ack_i || w_to_term) begin
                    w_rsp_valid_nxt = 1'b1;
                    if (bus.wb_err_i) begin
                        w_rsp_err_nxt     = 1'b1;
                        w_rsp_timeout_nxt = 1'b0;
                        w_rsp_data_nxt    = '0;
                    end else if (bus.wb_ack_i) begin
                        w_rsp_err_nxt     = 1'b0;
                        w_rsp_timeout_nxt = 1'b0;
                        w_rsp_data_nxt    = r_we ? '0 : bus.wb_dat_i;
                    end else begin
                        w_rsp_err_nxt     = 1'b1;
                        w_rsp_timeout_nxt = 1'b1;
                        w_rsp_data_nxt    = '0;
                    end
                    // A timed-out slave gets at least one idle cycle with cyc low
                    if (!w_empty && !w_to_term) begin
                        w_pop = 1'b1;
                    end else begin
                        w_cyc_nxt   = 1'b0;
                        w_stb_nxt   = 1'b0;
                        w_we_nxt    = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_WL'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_pop) begin
            {w_we_nxt, w_sel_nxt, w_adr_nxt, w_dat_nxt} = w_head;
            w_cyc_nxt   = 1'b1;
            w_stb_nxt   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_ACTIVE;
        end
    end

    always_ff @(posedge clk or negedge a_reset_l) begin
        if (!a_reset_l) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_cyc         <= 1'b0;
            r_stb         <= 1'b0;
            r_we          <= 1'b0;
            r_sel         <= '0;
            r_adr         <= '0;
            r_dat         <= '0;
            r_cnt         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_data    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cyc         <= w_cyc_nxt;
            r_stb         <= w_stb_nxt;
            r_we          <= w_we_nxt;
            r_sel         <= w_sel_nxt;
            r_adr         <= w_adr_nxt;
            r_dat         <= w_dat_nxt;
            r_cnt         <= w_cnt_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_rsp_data    <= w_rsp_data_nxt;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_WL'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_WL'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_WL'(1);
                2'b01:   r_level <= r_level - LVL_WL'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign bus.wb_cyc_o      = r_cyc;
    assign bus.wb_stb_o      = r_stb;
    assign bus.wb_we_o       = r_we;
    assign bus.wb_sel_o      = r_sel;
    assign bus.wb_adr_o      = r_adr;
    assign bus.wb_dat_o      = r_dat;
    assign bus.cmd_ready_o   = !w_full;
    assign bus.rsp_valid_o   = r_rsp_valid;
    assign bus.rsp_data_o    = r_rsp_data;
    assign bus.rsp_err_o     = r_rsp_err;
    assign bus.rsp_timeout_o = r_rsp_timeout;
    assign bus.busy_o        = (r_state == S_ACTIVE) || !w_empty;
    assign bus.level_o       = r_level;
endmodule

// File: tb/tb_wb_queued_master.sv
// tb/tb_wb_queued_master.sv - directed self-checking bench for wb_queued_master
module tb_wb_queued_master;
    logic clk;
    logic a_reset_l;
    int   checks;
    int   errors;

    wb_queued_master_if #(.DATA_WL(16), .ADR_WL(16), .CMD_DEPTH(4)) bus ();

    wb_queued_master #(
        .DATA_WL(16), .ADR_WL(16), .CMD_DEPTH(4), .TIMEOUT(8)
    ) dut (
        .clk       (clk),
        .a_reset_l (a_reset_l),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic we, input logic [15:0] addr, input logic [15:0] data);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_sel_i   = 2'b11;
        bus.cmd_addr_i  = addr;
        bus.cmd_data_i  = data;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        a_reset_l       = 1'b0;
        bus.wb_ack_i    = 1'b0;
        bus.wb_err_i    = 1'b0;
        bus.wb_dat_i    = '0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_sel_i   = '0;
        bus.cmd_addr_i  = '0;
        bus.cmd_data_i  = '0;
        step(2);
        chk("rst_cyc",   32'(bus.wb_cyc_o), 0);
        chk("rst_stb",   32'(bus.wb_stb_o), 0);
        chk("rst_ready", 32'(bus.cmd_ready_o), 1);
        chk("rst_level", 32'(bus.level_o), 0);
        chk("rst_busy",  32'(bus.busy_o), 0);
        chk("rst_rspv",  32'(bus.rsp_valid_o), 0);
        a_reset_l = 1'b1;
        step(1);

        // single read, two wait states
        set_cmd(1'b0, 16'h0010, 16'h0000);
        step(1);
        bus.cmd_valid_i = 1'b0;
        chk("rd_level_push", 32'(bus.level_o), 1);
        chk("rd_cyc_pre",    32'(bus.wb_cyc_o), 0);
        chk("rd_busy",       32'(bus.busy_o), 1);
        step(1);
        chk("rd_cyc1", 32'(bus.wb_cyc_o), 1);
        chk("rd_stb1", 32'(bus.wb_stb_o), 1);
        chk("rd_adr",  32'(bus.wb_adr_o), 32'h0010);
        chk("rd_sel",  32'(bus.wb_sel_o), 32'h3);
        chk("rd_we",   32'(bus.wb_we_o), 0);
        chk("rd_level_pop", 32'(bus.level_o), 0);
        step(1);
        chk("rd_cyc2", 32'(bus.wb_cyc_o), 1);
        chk("rd_rspv_wait", 32'(bus.rsp_valid_o), 0);
        step(1);
        chk("rd_cyc3", 32'(bus.wb_cyc_o), 1);
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = 16'hBEEF;
        step(1);
        bus.wb_ack_i = 1'b0;
        chk("rd_rspv",  32'(bus.rsp_valid_o), 1);
        chk("rd_data",  32'(bus.rsp_data_o), 32'hBEEF);
        chk("rd_err",   32'(bus.rsp_err_o), 0);
        chk("rd_cyc_end", 32'(bus.wb_cyc_o), 0);
        step(1);
        chk("rd_rspv_once", 32'(bus.rsp_valid_o), 0);
        chk("rd_data_hold", 32'(bus.rsp_data_o), 32'hBEEF);
        chk("rd_busy_end",  32'(bus.busy_o), 0);

        // burst fill to full, then push/pop at full
        for (int k = 0; k < 5; k++) begin
            set_cmd(1'b1, 16'h0100 + 16'(k), 16'hA000 + 16'(k));
            step(1);
        end
        chk("full_level", 32'(bus.level_o), 4);
        chk("full_ready", 32'(bus.cmd_ready_o), 0);
        chk("full_adr",   32'(bus.wb_adr_o), 32'h0100);
        chk("full_we",    32'(bus.wb_we_o), 1);
        set_cmd(1'b1, 16'h0105, 16'hA005);
        bus.wb_ack_i = 1'b1;
        step(1);
        chk("pp_level_nopush", 32'(bus.level_o), 3);
        chk("pp_ready",        32'(bus.cmd_ready_o), 1);
        chk("pp_rspv",         32'(bus.rsp_valid_o), 1);
        chk("pp_rsp_data",     32'(bus.rsp_data_o), 0);
        chk("pp_adr1",         32'(bus.wb_adr_o), 32'h0101);
        step(1);
        bus.cmd_valid_i = 1'b0;
        chk("pp_level_push", 32'(bus.level_o), 3);
        chk("pp_adr2",       32'(bus.wb_adr_o), 32'h0102);
        chk("pp_dat2",       32'(bus.wb_dat_o), 32'hA002);
        chk("pp_cyc2",       32'(bus.wb_cyc_o), 1);
        for (int k = 3; k < 6; k++) begin
            step(1);
            chk("bu_adr",   32'(bus.wb_adr_o), 32'h0100 + 32'(k));
            chk("bu_dat",   32'(bus.wb_dat_o), 32'hA000 + 32'(k));
            chk("bu_cyc",   32'(bus.wb_cyc_o), 1);
            chk("bu_rspv",  32'(bus.rsp_valid_o), 1);
            chk("bu_level", 32'(bus.level_o), 32'(5 - k));
        end
        step(1);
        bus.wb_ack_i = 1'b0;
        chk("bu_cyc_end",  32'(bus.wb_cyc_o), 0);
        chk("bu_rspv_end", 32'(bus.rsp_valid_o), 1);
        chk("bu_data_end", 32'(bus.rsp_data_o), 0);
        step(1);
        chk("bu_rspv_off", 32'(bus.rsp_valid_o), 0);
        chk("bu_busy_off", 32'(bus.busy_o), 0);

        // err wins over ack
        set_cmd(1'b0, 16'h0020, 16'h0000);
        step(1);
        bus.cmd_valid_i = 1'b0;
        step(1);
        chk("er_cyc", 32'(bus.wb_cyc_o), 1);
        bus.wb_ack_i = 1'b1;
        bus.wb_err_i = 1'b1;
        bus.wb_dat_i = 16'h1234;
        step(1);
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        chk("er_rspv", 32'(bus.rsp_valid_o), 1);
        chk("er_err",  32'(bus.rsp_err_o), 1);
        chk("er_data", 32'(bus.rsp_data_o), 0);
        chk("er_to",   32'(bus.rsp_timeout_o), 0);
        chk("er_cyc_end", 32'(bus.wb_cyc_o), 0);

        // timeout with a second command queued
        set_cmd(1'b0, 16'h0030, 16'h0000);
        step(1);
        set_cmd(1'b0, 16'h0031, 16'h0000);
        step(1);
        bus.cmd_valid_i = 1'b0;
        chk("to_cyc0", 32'(bus.wb_cyc_o), 1);
        chk("to_adr0", 32'(bus.wb_adr_o), 32'h0030);
        for (int i = 0; i < 7; i++) begin
            step(1);
            chk("to_cyc_hold", 32'(bus.wb_cyc_o), 1);
        end
        step(1);
        chk("to_cyc_rel", 32'(bus.wb_cyc_o), 0);
        chk("to_rspv",    32'(bus.rsp_valid_o), 1);
        chk("to_err",     32'(bus.rsp_err_o), 1);
        chk("to_to",      32'(bus.rsp_timeout_o), 1);
        chk("to_data",    32'(bus.rsp_data_o), 0);
        chk("to_level",   32'(bus.level_o), 1);
        step(1);
        chk("to_next_cyc",  32'(bus.wb_cyc_o), 1);
        chk("to_next_adr",  32'(bus.wb_adr_o), 32'h0031);
        chk("to_next_rspv", 32'(bus.rsp_valid_o), 0);
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = 16'h5555;
        step(1);
        bus.wb_ack_i = 1'b0;
        chk("to2_rspv", 32'(bus.rsp_valid_o), 1);
        chk("to2_err",  32'(bus.rsp_err_o), 0);
        chk("to2_to",   32'(bus.rsp_timeout_o), 0);
        chk("to2_data", 32'(bus.rsp_data_o), 32'h5555);

        // asynchronous reset mid-transfer
        for (int k = 0; k < 3; k++) begin
            set_cmd(1'b1, 16'h0040 + 16'(k), 16'hC000 + 16'(k));
            step(1);
        end
        bus.cmd_valid_i = 1'b0;
        chk("mr_level_pre", 32'(bus.level_o), 2);
        chk("mr_cyc_pre",   32'(bus.wb_cyc_o), 1);
        #3;
        a_reset_l = 1'b0;
        #1;
        chk("mr_cyc",   32'(bus.wb_cyc_o), 0);
        chk("mr_stb",   32'(bus.wb_stb_o), 0);
        chk("mr_we",    32'(bus.wb_we_o), 0);
        chk("mr_adr",   32'(bus.wb_adr_o), 0);
        chk("mr_level", 32'(bus.level_o), 0);
        chk("mr_ready", 32'(bus.cmd_ready_o), 1);
        chk("mr_busy",  32'(bus.busy_o), 0);
        chk("mr_rspd",  32'(bus.rsp_data_o), 0);
        chk("mr_rspv",  32'(bus.rsp_valid_o), 0);
        step(1);
        #3;
        a_reset_l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("mr_post_rspv", 32'(bus.rsp_valid_o), 0);
            chk("mr_post_cyc",  32'(bus.wb_cyc_o), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_queued_master.md
# wb_queued_master

Parametrised Wishbone classic master that succeeds the single-shot chip-side bridge: chip logic queues transfers through a command FIFO, and the block executes them back-to-back on the bus. Adds byte selects, bus-error handling, a per-transfer timeout and a one-cycle response strobe per completed transfer. Sits between chip-side initiators and the external Wishbone fabric.

## Interface

- DATA_WL, 16, data width; multiple of 8.
- ADR_WL, 16, address width.
- CMD_DEPTH, 4, command FIFO entries; power of 2, ≥2.
- TIMEOUT, 255, max cycles waiting for ack/err; 0 disables the timeout.

Ports:

- clk  in  1  clock.
- a_reset_l  in  1  reset, asynchronous, active-low.
- wb_ack_i  in  1  slave acknowledge.
- wb_err_i  in  1  slave error.
- wb_dat_i  in  DATA_WL  read data.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe.
- wb_we_o  out  1  write enable.
- wb_sel_o  out  DATA_WL/8  byte selects.
- wb_adr_o  out  ADR_WL  address.
- wb_dat_o  out  DATA_WL  write data.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  FIFO not full.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_sel_i  in  DATA_WL/8  byte selects.
- cmd_addr_i  in  ADR_WL  address.
- cmd_data_i  in  DATA_WL  write data.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_data_o  out  DATA_WL  read data; 0 for writes and for failed transfers.
- rsp_err_o  out  1  transfer ended by wb_err_i or by timeout.
- rsp_timeout_o  out  1  transfer ended by timeout.
- busy_o  out  1  transfer in flight or FIFO non-empty.
- level_o  out  $clog2(CMD_DEPTH)+1  FIFO occupancy.

## Operation

- **FIFO**
  - A push occurs when cmd_valid_i && cmd_ready_o.
  - cmd_ready_o = (level_o != CMD_DEPTH), combinational from the count.
  - Entry = {we, sel, addr, data}. Pointers wrap modulo CMD_DEPTH.
  - Push and pop in the same cycle leave level_o unchanged.
- **FSM states:** IDLE, ACTIVE.
- **IDLE**
  - If the FIFO is non-empty: pop the head; register it onto wb_adr_o/wb_dat_o/wb_we_o/wb_sel_o; set cyc = stb = 1; clear the timeout counter; go to ACTIVE.
  - Otherwise cyc, stb and we are 0.
- **ACTIVE:** termination is sampled each clock, with priority err > ack > timeout.
  - err: rsp_err_o = 1, rsp_data_o = 0.
  - ack: read transfers latch wb_dat_i into rsp_data_o; write transfers drive rsp_data_o = 0; rsp_err_o = 0.
  - timeout: the counter reaches TIMEOUT-1 with neither ack nor err. Result is rsp_err_o = 1, rsp_timeout_o = 1, rsp_data_o = 0. The bus is released.
  - No termination: hold all bus outputs and increment the counter.
- **On termination:**
  - rsp_valid_o = 1 for exactly one cycle.
  - If the FIFO is non-empty, pop the next command at the same edge. cyc and stb stay 1, the new address and data appear, the counter clears, and the FSM stays in ACTIVE.
  - If the FIFO is empty, cyc, stb and we go to 0 and the FSM goes to IDLE.
  - A timeout termination always forces IDLE, dropping cyc for at least one cycle, even when the FIFO is non-empty.
- **Responses:** no backpressure. rsp_data_o, rsp_err_o and rsp_timeout_o hold their values until the next response.
- **busy_o** = (state == ACTIVE) || (level_o != 0), registered-state based.
- **Reset**, asynchronous and legal at any time including mid-transfer:
  - FSM to IDLE; FIFO emptied; counter 0.
  - Every output 0, except cmd_ready_o = 1.
  - No response is generated for discarded transfers.

## Timing

- A command pushed at edge N into an empty, idle block drives cyc/stb/adr from edge N+1.
- Termination sampled at edge M:
  - rsp_valid_o is high in the cycle following M.
  - A queued next command is on the bus from edge M.
  - Zero-wait-state acks therefore sustain one transfer per clock.
- Timeout fires TIMEOUT cycles after stb rose: rsp_valid_o is high in the following cycle and cyc is 0.
- With TIMEOUT = 0, the master waits indefinitely.

## Test plan

- **Single read:** push read at addr 0x0010 while the slave acks after 2 wait cycles with 0xBEEF. Expect cyc/stb high for 3 cycles, sel = 2'b11, one rsp_valid_o with rsp_data_o = 0xBEEF and rsp_err_o = 0.
- **Burst fill:** push 4 writes (0x0100..0x0103, data 0xA000..0xA003) with a zero-wait slave.
  - cmd_ready_o drops while level_o = 4.
  - cyc stays high for 4 consecutive cycles with addresses in order.
  - 4 consecutive rsp_valid_o pulses occur, each with rsp_data_o = 0.
- **Error priority:** a read where the slave raises wb_ack_i and wb_err_i together. Expect rsp_err_o = 1, rsp_data_o = 0, rsp_timeout_o = 0.
- **Timeout:** TIMEOUT = 8 and a slave that never responds.
  - cyc is released after 8 cycles, with rsp_err_o = 1 and rsp_timeout_o = 1.
  - A second queued command starts only after a cyc-low cycle.
- **Reset mid-operation:** 3 commands queued and the first stalled. Assert a_reset_l low asynchronously between edges.
  - All outputs go to 0 immediately, with cmd_ready_o = 1 and level_o = 0.
  - No rsp_valid_o pulse follows after release.
- **Simultaneous push/pop at full:** level_o = 4 and an ack arrives with cmd_valid_i high. Expect no push that cycle (ready = 0), level_o goes to 3, then the push is accepted the next cycle.
